int_to_float: RTL

Converts a stream of 32-bit two's-complement integers into IEEE-754 single-precision floats, rounding to nearest, ties to even. It sits directly upstream of the result file writer in the int_to_float test chain. It consumes words from the stimulus reader on port `a` and presents results on port `z` using the codebase's stb/ack handshake. A multi-cycle state machine handles one word at a time.

---
 rtl/int_to_float.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/int_to_float.sv
// ============================================================================
// Module   : int_to_float
// Brief    : 32-bit two's-complement integer to IEEE-754 single converter
//            (round to nearest, ties to even) with stb/ack handshake.
//            Define INT_TO_FLOAT_FAST_NORM_EN for a single-cycle normaliser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [2:0] S_GET_A     = 3'd0;
  localparam logic [2:0] S_CONVERT   = 3'd1;
  localparam logic [2:0] S_NORMALISE = 3'd2;
  localparam logic [2:0] S_ROUND     = 3'd3;
  localparam logic [2:0] S_PACK      = 3'd4;
  localparam logic [2:0] S_PUT_Z     = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [31:0] r_a;
  logic [31:0] r_v;
  logic [5:0]  r_e;
  logic [22:0] r_frac;
  logic        r_sign;
  logic        r_ack;
  logic        r_stb;
  logic [31:0] r_z;
  logic        w_ack_nxt;
  logic        w_stb_nxt;
  logic [31:0] w_abs;
  logic        w_round_up;
  logic        w_m_ovf;
  logic [7:0]  w_exp;

  assign w_abs      = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_round_up = r_v[7] & (r_v[6] | (|r_v[5:0]) | r_v[8]);
  // An all-ones mantissa that rounds up wraps the fraction to zero; only the exponent moves.
  assign w_m_ovf    = (&r_v[31:8]) & w_round_up;
  assign w_exp      = {2'b00, r_e} + 8'd127;

`ifdef INT_TO_FLOAT_FAST_NORM_EN
  logic [4:0] w_lz;
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_v[i]) w_lz = 5'(31 - i);
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_GET_A;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_GET_A:     if (r_ack && input_a_stb) w_state_nxt = S_CONVERT;
      S_CONVERT:   w_state_nxt = (r_a == 32'd0) ? S_PUT_Z : S_NORMALISE;
`ifdef INT_TO_FLOAT_FAST_NORM_EN
      S_NORMALISE: w_state_nxt = S_ROUND;
`else
      S_NORMALISE: if (r_v[31]) w_state_nxt = S_ROUND;
`endif
      S_ROUND:     w_state_nxt = S_PACK;
      S_PACK:      w_state_nxt = S_PUT_Z;
      S_PUT_Z:     if (r_stb && output_z_ack) w_state_nxt = S_GET_A;
      default:     w_state_nxt = S_GET_A;
    endcase
  end

  // Output logic: the handshake flags are registered, so decode their next values here.
  always_comb begin
    w_ack_nxt = (r_state == S_GET_A) && !(r_ack && input_a_stb);
    w_stb_nxt = (w_state_nxt == S_PUT_Z);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= 32'd0;
      r_v    <= 32'd0;
      r_e    <= 6'd0;
      r_frac <= 23'd0;
      r_sign <= 1'b0;
      r_ack  <= 1'b0;
      r_stb  <= 1'b0;
      r_z    <= 32'd0;
    end else begin
      r_ack <= w_ack_nxt;
      r_stb <= w_stb_nxt;
      case (r_state)
        S_GET_A: if (r_ack && input_a_stb) r_a <= input_a;
        S_CONVERT: begin
          r_sign <= r_a[31];
          r_v    <= w_abs;
          r_e    <= 6'd31;
          if (r_a == 32'd0) r_z <= 32'd0;
        end
`ifdef INT_TO_FLOAT_FAST_NORM_EN
        S_NORMALISE: begin
          r_v <= r_v << w_lz;
          r_e <= 6'd31 - {1'b0, w_lz};
        end
`else
        S_NORMALISE: begin
          if (!r_v[31]) begin
            r_v <= {r_v[30:0], 1'b0};
            r_e <= r_e - 6'd1;
          end
        end
`endif
        S_ROUND: begin
          r_frac <= r_v[30:8] + {22'd0, w_round_up};
          r_e    <= r_e + {5'd0, w_m_ovf};
        end
        S_PACK:  r_z <= {r_sign, w_exp, r_frac};
        default: ;
      endcase
    end
  end

  assign input_a_ack  = r_ack;
  assign output_z_stb = r_stb;
  assign output_z     = r_z;

endmodule

`default_nettype wire
